// File: rtl/truth_table_scanner.sv
// Clocked sequencer that walks an external combinational function through every
// input vector, captures its truth table, counts the ones and checks it against a reference.
module truth_table_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      func_in,
    input  logic                 func_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        ones_count,
    output logic                 match,
    output logic [N_IN-1:0]      mismatch_idx,
    output logic [1:0]           state_dbg
);

    localparam int TW = 2**N_IN;
    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    // Handshake: start is a level sampled on the rising edge and is only acted on in
    // IDLE; abort is likewise a sampled level, acted on in DRIVE/SAMPLE (and IDLE).
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [N_IN-1:0] idx;
    logic [SW-1:0]   settle;
    logic [TW-1:0]   exp_q;
    logic [TW-1:0]   table_next;
    logic [TW-1:0]   diff;
    logic [N_IN-1:0] first_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start && !abort) state_n = S_DRIVE;
            S_DRIVE: begin
                if (abort)                   state_n = S_IDLE;
                else if (settle <= SW'(1))   state_n = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)                   state_n = S_IDLE;
                else if (idx == LAST_IDX)    state_n = S_DONE;
                else                         state_n = S_DRIVE;
            end
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Compare against the table including the bit being written this cycle, so match
    // and mismatch_idx are already valid while done is high.
    always_comb begin
        table_next      = table_out;
        table_next[idx] = func_out;
        diff            = table_next ^ exp_q;
        first_diff      = '0;
        for (int i = TW - 1; i >= 0; i--) begin
            if (diff[i]) first_diff = N_IN'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            settle       <= '0;
            exp_q        <= '0;
            table_out    <= '0;
            ones_count   <= '0;
            match        <= 1'b0;
            mismatch_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        exp_q        <= expected;
                        table_out    <= '0;
                        ones_count   <= '0;
                        match        <= 1'b0;
                        mismatch_idx <= '0;
                        idx          <= '0;
                        settle       <= SW'(SETTLE);
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        idx          <= '0;
                        settle       <= '0;
                        table_out    <= '0;
                        ones_count   <= '0;
                        match        <= 1'b0;
                        mismatch_idx <= '0;
                    end else if (settle > SW'(1)) begin
                        settle <= settle - SW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        idx          <= '0;
                        settle       <= '0;
                        table_out    <= '0;
                        ones_count   <= '0;
                        match        <= 1'b0;
                        mismatch_idx <= '0;
                    end else begin
                        table_out  <= table_next;
                        ones_count <= ones_count + {{N_IN{1'b0}}, func_out};
                        // The last increment wraps idx to 0, returning func_in to 0.
                        idx        <= idx + 1'b1;
                        settle     <= SW'(SETTLE);
                        if (idx == LAST_IDX) begin
                            match        <= (diff == '0);
                            mismatch_idx <= first_diff;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign func_in   = idx;
    assign busy      = (state == S_DRIVE) || (state == S_SAMPLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: minterm and constant functions,
// mid-scan start/expected changes, abort, asynchronous reset, and a SETTLE=3 instance.
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst_n, start, start3, abort, mode;
    logic [15:0] expected;

    logic [3:0]  func_in, func_in3;
    logic        func_out, func_out3;
    logic        busy, busy3, done, done3, match, match3;
    logic [15:0] table_out, table_out3;
    logic [4:0]  ones_count, ones_count3;
    logic [3:0]  mismatch_idx, mismatch_idx3;
    logic [1:0]  state_dbg, state_dbg3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // f = (~c & d) | (a & b & c & d), a = MSB of the vector
    function automatic logic f_min(input logic [3:0] v);
        return (~v[1] & v[0]) | (v[3] & v[2] & v[1] & v[0]);
    endfunction

    assign func_out  = mode ? 1'b1 : f_min(func_in);
    assign func_out3 = mode ? 1'b1 : f_min(func_in3);

    truth_table_scanner #(.N_IN(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .func_in(func_in), .func_out(func_out), .busy(busy), .done(done),
        .table_out(table_out), .ones_count(ones_count), .match(match),
        .mismatch_idx(mismatch_idx), .state_dbg(state_dbg)
    );

    truth_table_scanner #(.N_IN(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .expected(expected),
        .func_in(func_in3), .func_out(func_out3), .busy(busy3), .done(done3),
        .table_out(table_out3), .ones_count(ones_count3), .match(match3),
        .mismatch_idx(mismatch_idx3), .state_dbg(state_dbg3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge just after the edge that accepted start.
    task automatic do_start(input bit which, input logic [15:0] exp);
        @(negedge clk);
        expected = exp;
        if (which) start3 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    // Follows a scan until done, checking the func_in sequence and counting busy cycles.
    // inject drives a stray start with a different expected value mid-scan.
    task automatic wait_scan(input bit which, input int settle, input bit inject,
                             output int bcyc, output bit got);
        int bad;
        logic d, b;
        logic [3:0] fi;
        bad  = 0;
        bcyc = 0;
        got  = 1'b0;
        for (int k = 0; k < 300; k++) begin
            d  = which ? done3 : done;
            b  = which ? busy3 : busy;
            fi = which ? func_in3 : func_in;
            if (d) begin
                got = 1'b1;
                break;
            end
            if (b) begin
                if (fi !== 4'(bcyc / (settle + 1))) bad++;
                bcyc++;
            end
            if (inject && k == 9) begin
                start    = 1'b1;
                expected = 16'h0000;
            end else if (inject && k == 10) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("func_in_seq", 32'(bad), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] tbl, input logic [4:0] ones,
                                input logic m, input logic [3:0] mi);
        chk({tag, "_table"},   32'(table_out),    32'(tbl));
        chk({tag, "_ones"},    32'(ones_count),   32'(ones));
        chk({tag, "_match"},   32'(match),        32'(m));
        chk({tag, "_mis_idx"}, 32'(mismatch_idx), 32'(mi));
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  bc;
        bit  got;
        int  dcount;
        rst_n    = 1'b0;
        start    = 1'b0;
        start3   = 1'b0;
        abort    = 1'b0;
        mode     = 1'b0;
        expected = 16'h0;

        // Reset and idle values
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_func_in", 32'(func_in), 32'd0);
        chk("rst_table", 32'(table_out), 32'd0);
        chk("rst_ones", 32'(ones_count), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_mis_idx", 32'(mismatch_idx), 32'd0);

        // Minterm function, matching expected; stray start/expected change mid-scan
        do_start(1'b0, 16'hA222);
        wait_scan(1'b0, 1, 1'b1, bc, got);
        chk("s2_done_seen", 32'(got), 32'd1);
        chk("s2_busy_cycles", 32'(bc), 32'd32);
        check_result("s2", 16'hA222, 5'd5, 1'b1, 4'd0);
        @(negedge clk);
        chk("s2_done_pulse", 32'(done), 32'd0);
        chk("s2_idle_func_in", 32'(func_in), 32'd0);
        chk("s2_hold_table", 32'(table_out), 32'hA222);
        chk("s2_hold_match", 32'(match), 32'd1);

        // Same function, reference differs at bit 5
        do_start(1'b0, 16'hA202);
        wait_scan(1'b0, 1, 1'b0, bc, got);
        chk("s3_done_seen", 32'(got), 32'd1);
        check_result("s3", 16'hA222, 5'd5, 1'b0, 4'd5);

        // Constant-one function: full count without overflow
        mode = 1'b1;
        do_start(1'b0, 16'hFFFF);
        wait_scan(1'b0, 1, 1'b0, bc, got);
        chk("s4_done_seen", 32'(got), 32'd1);
        check_result("s4", 16'hFFFF, 5'd16, 1'b1, 4'd0);
        do_start(1'b0, 16'hFFFE);
        wait_scan(1'b0, 1, 1'b0, bc, got);
        chk("s4b_done_seen", 32'(got), 32'd1);
        check_result("s4b", 16'hFFFF, 5'd16, 1'b0, 4'd0);

        // Abort mid-scan with extra start pulses while busy
        mode = 1'b0;
        do_start(1'b0, 16'hA222);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("s5_busy_before_abort", 32'(busy), 32'd1);
        chk("s5_table_before_abort", 32'(table_out != 16'h0), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("s5_abort_busy", 32'(busy), 32'd0);
        chk("s5_abort_done", 32'(done), 32'd0);
        chk("s5_abort_table", 32'(table_out), 32'd0);
        chk("s5_abort_ones", 32'(ones_count), 32'd0);
        chk("s5_abort_func_in", 32'(func_in), 32'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) dcount++;
            @(negedge clk);
        end
        chk("s5_no_done_after_abort", 32'(dcount), 32'd0);
        do_start(1'b0, 16'hA222);
        wait_scan(1'b0, 1, 1'b0, bc, got);
        chk("s5_rescan_done_seen", 32'(got), 32'd1);
        chk("s5_rescan_busy_cycles", 32'(bc), 32'd32);
        check_result("s5_rescan", 16'hA222, 5'd5, 1'b1, 4'd0);

        // Asynchronous reset mid-scan at idx 7
        do_start(1'b0, 16'hA222);
        repeat (14) @(negedge clk);
        chk("s6_func_in_before_rst", 32'(func_in), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_func_in", 32'(func_in), 32'd0);
        chk("s6_rst_table", 32'(table_out), 32'd0);
        chk("s6_rst_ones", 32'(ones_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s6_idle_state", 32'(state_dbg), 32'd0);
        chk("s6_idle_done", 32'(done), 32'd0);
        do_start(1'b0, 16'hA222);
        wait_scan(1'b0, 1, 1'b0, bc, got);
        chk("s6_rescan_done_seen", 32'(got), 32'd1);
        check_result("s6_rescan", 16'hA222, 5'd5, 1'b1, 4'd0);

        // SETTLE=3 instance: 64 busy cycles, done in cycle 65
        do_start(1'b1, 16'hA222);
        wait_scan(1'b1, 3, 1'b0, bc, got);
        chk("s7_done_seen", 32'(got), 32'd1);
        chk("s7_busy_cycles", 32'(bc), 32'd64);
        chk("s7_table", 32'(table_out3), 32'hA222);
        chk("s7_ones", 32'(ones_count3), 32'd5);
        chk("s7_match", 32'(match3), 32'd1);
        chk("s7_mis_idx", 32'(mismatch_idx3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
